// File: rtl/o_serdes_x3_train_tx_if.sv
// Handshake and serial-output bundle for o_serdes_x3_train_tx.
// underrun_cnt exists only when O_SERDES_TX_UNDERRUN_CNT_EN is defined.
`timescale 1ns/1ps
interface o_serdes_x3_train_tx_if #(
  parameter int WIDTH = 3
);
  // valid/ack: data_valid and data_i are held by the source until data_ack;
  // data_ack is combinational and high only on a slot boundary that takes the word.
  logic             enable_n;
  logic             train_req;
  logic [WIDTH-1:0] data_i;
  logic             data_valid;
  logic             data_ack;
  logic             data_o;
  logic             oe;
  logic             tx_ready;
  logic             underrun;
  logic [1:0]       dbg_state;
`ifdef O_SERDES_TX_UNDERRUN_CNT_EN
  logic [7:0]       underrun_cnt;

  modport master (
    output enable_n, train_req, data_i, data_valid,
    input  data_ack, data_o, oe, tx_ready, underrun, dbg_state, underrun_cnt
  );
  modport slave (
    input  enable_n, train_req, data_i, data_valid,
    output data_ack, data_o, oe, tx_ready, underrun, dbg_state, underrun_cnt
  );
`else
  modport master (
    output enable_n, train_req, data_i, data_valid,
    input  data_ack, data_o, oe, tx_ready, underrun, dbg_state
  );
  modport slave (
    input  enable_n, train_req, data_i, data_valid,
    output data_ack, data_o, oe, tx_ready, underrun, dbg_state
  );
`endif
endinterface

// File: rtl/o_serdes_x3_train_tx.sv
// MSB-first serializer with training burst ahead of payload and underrun fill.
// Optional saturating underrun counter: define O_SERDES_TX_UNDERRUN_CNT_EN.
`timescale 1ns/1ps
module o_serdes_x3_train_tx #(
  parameter int               WIDTH         = 3,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 3'b100,
  parameter int               TRAIN_WORDS   = 16,
  parameter logic [WIDTH-1:0] IDLE_WORD     = 3'b000
) (
  input logic                   clk,
  input logic                   reset,
  o_serdes_x3_train_tx_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_RUN} state_e;

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [7:0]      TRAIN_LAST = 8'(TRAIN_WORDS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             oe_q, oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             underrun_q, underrun_d;
  logic             data_ack;
  logic             boundary;
  logic             load_run;
  logic             go_idle;

  assign boundary = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      wcnt_q     <= '0;
      oe_q       <= 1'b0;
      tx_ready_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      wcnt_q     <= wcnt_d;
      oe_q       <= oe_d;
      tx_ready_q <= tx_ready_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = boundary ? '0 : cnt_q + CW'(1);
    shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
    wcnt_d     = wcnt_q;
    oe_d       = oe_q;
    tx_ready_d = tx_ready_q;
    underrun_d = 1'b0;
    data_ack   = 1'b0;
    load_run   = 1'b0;
    go_idle    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        shreg_d = '0;
        if (!bus.enable_n) begin
          state_d = ST_TRAIN;
          shreg_d = TRAIN_PATTERN;
          wcnt_d  = 8'd1;
          oe_d    = 1'b1;
        end
      end
      ST_TRAIN: begin
        if (bus.enable_n) begin
          go_idle = 1'b1;
        end else if (boundary) begin
          if (wcnt_q == TRAIN_LAST) begin
            load_run   = 1'b1;
            state_d    = ST_RUN;
            tx_ready_d = 1'b1;
          end else begin
            shreg_d = TRAIN_PATTERN;
            wcnt_d  = wcnt_q + 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (bus.enable_n) begin
          go_idle = 1'b1;
        end else if (boundary) begin
          // Retrain wins over pending payload; the word stays with the source.
          if (bus.train_req) begin
            shreg_d    = TRAIN_PATTERN;
            wcnt_d     = 8'd1;
            tx_ready_d = 1'b0;
            state_d    = ST_TRAIN;
          end else begin
            load_run = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_idle) begin
      state_d    = ST_IDLE;
      shreg_d    = '0;
      cnt_d      = '0;
      oe_d       = 1'b0;
      tx_ready_d = 1'b0;
    end

    if (load_run) begin
      if (bus.data_valid) begin
        data_ack = 1'b1;
        shreg_d  = bus.data_i;
      end else begin
        shreg_d    = IDLE_WORD;
        underrun_d = 1'b1;
      end
    end
  end

`ifdef O_SERDES_TX_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (state_d == ST_TRAIN && state_q != ST_TRAIN) begin
      ucnt_d = '0;
    end else if (underrun_q && ucnt_q != 8'hFF) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign bus.underrun_cnt = ucnt_q;
`endif

  assign bus.data_o    = shreg_q[WIDTH-1];
  assign bus.data_ack  = data_ack;
  assign bus.oe        = oe_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.underrun  = underrun_q;
  assign bus.dbg_state = state_q;
endmodule
